img_mem_arbiter: RTL and testbench
==================================

IMG_MEM_ARBITER -- requirements
Module: img_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 19, image RAM address width; DATA_W, 8, pixel width; STARVE_LIMIT, 4, consecutive CPU-denied cycles before a forced CPU grant.
REQ-002 Ports SHALL be, in order:
clk  in  1  single clock; all state on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request (held until cpu_stall low)
cpu_we  in  1  1=write, 0=read
cpu_adr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU must hold request and PC
cpu_rdata  out  DATA_W  registered CPU read data
vga_req  in  1  display read request
vga_adr  in  ADDR_W  display address
vga_gnt  out  1  display request accepted this cycle
vga_rvalid  out  1  vga_rdata valid
vga_rdata  out  DATA_W  display read data
ram_adr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  DATA_W  RAM output, valid one cycle after address

Function
REQ-003 At most one requester SHALL own the RAM port per cycle; grant decided combinationally from current inputs and registered state.
REQ-004 Default priority SHALL be vga_req over cpu_req.
REQ-005 Owner's address/data SHALL drive ram_adr/ram_wdata same cycle; ram_we=1 only on a granted CPU write; idle cycles drive ram_adr=0, ram_we=0.
REQ-006 vga_gnt SHALL equal the VGA grant; vga_rvalid SHALL pulse exactly one cycle after each vga_gnt, with vga_rdata=ram_q.
REQ-007 CPU FSM states SHALL be C_IDLE, C_RD_WAIT, C_RD_DONE.
REQ-008 C_IDLE: granted write completes that cycle, cpu_stall=0; granted read -> C_RD_WAIT, cpu_stall=1; ungranted cpu_req -> cpu_stall=1, stay.
REQ-009 C_RD_WAIT: capture ram_q into cpu_rdata, cpu_stall=1, -> C_RD_DONE; port free for VGA this cycle.
REQ-010 C_RD_DONE: cpu_stall=0, cpu_rdata held, no CPU grant, -> C_IDLE.
REQ-011 cpu_stall SHALL be 0 whenever cpu_req=0 in C_IDLE.
REQ-012 A one-bit read-tag pipeline SHALL route ram_q to CPU or VGA by last cycle's owner; back-to-back VGA grants SHALL yield back-to-back vga_rvalid.
REQ-013 cpu_rdata SHALL hold last captured value until the next CPU read capture.
REQ-014 Changing cpu_adr/cpu_we while stalled is illegal; behaviour undefined.

Reset
REQ-015 While reset=1 at a clock edge: FSM->C_IDLE, tag and starvation counter cleared, cpu_rdata=0.
REQ-016 While reset=1, all grants SHALL be 0: cpu_stall=0, vga_gnt=0, vga_rvalid=0, ram_we=0, ram_adr=0, ram_wdata=0.
REQ-017 Reset during C_RD_WAIT/C_RD_DONE SHALL abandon the read; no rvalid or capture on the following cycle.

Configuration
REQ-018 Macro IMG_ARB_STARVE_GUARD_EN defined: counter increments each C_IDLE cycle with cpu_req=1 not granted, clears on CPU grant or cpu_req=0, saturates at STARVE_LIMIT; at STARVE_LIMIT CPU SHALL win over vga_req.
REQ-019 Macro undefined: no counter; strict VGA priority; CPU may starve indefinitely.

Verification
REQ-020 Write: cpu_req=1, cpu_we=1, adr=0x00010, wdata=0xA5, vga_req=0 -> same cycle ram_we=1, ram_adr=0x00010, cpu_stall=0.
REQ-021 Read: cpu_req=1, cpu_we=0, adr=0x00010 after REQ-020 -> cpu_stall 1,1,0 over three cycles; cpu_rdata=0xA5 in third.
REQ-022 Collision: vga_req=1 adr=0x00020, cpu write requested same cycle -> vga_gnt=1, cpu_stall=1; CPU write completes first cycle vga_req=0.
REQ-023 Guard on, STARVE_LIMIT=4, vga_req and cpu_req held 1 -> CPU granted on 5th cycle, vga_gnt=0 that cycle; guard off -> CPU never granted.
REQ-024 VGA stream: vga_req=1 for 8 cycles, adr 0..7, RAM preloaded adr=data -> vga_rvalid 8 consecutive cycles, one cycle lagging, data 0..7; CPU read interleaved in C_RD_WAIT does not corrupt either.
REQ-025 Reset asserted in C_RD_WAIT -> next cycle C_IDLE, cpu_stall=0, vga_rvalid=0, cpu_rdata=0.

Source files
------------

// File: rtl/img_mem_arbiter.sv
// Purpose : shares one synchronous image RAM port between a stalling CPU and a display (VGA) reader.
// Latency : grant/address combinational in the request cycle; read data one cycle later (VGA) or
//           registered into cpu_rdata two cycles later (CPU). Backpressure: CPU held off via cpu_stall,
//           VGA sees vga_gnt=0 when refused. Optional CPU starvation guard: IMG_ARB_STARVE_GUARD_EN.
module img_mem_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_adr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    // CPU access sequencer states.
    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_RD_WAIT = 2'd1;
    localparam logic [1:0] C_RD_DONE = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;

    // The CPU can only contend for the port from C_IDLE; the wait/done
    // states leave the port to the display.
    logic cpu_claim;
    logic starve_force;
    logic vga_grant;
    logic cpu_grant;

    // Read-return pipeline: a valid bit plus a one-bit owner tag
    // (1 = CPU, 0 = VGA) recording who addressed the RAM last cycle.
    logic rd_vld_q;
    logic rd_tag_q;
    logic cpu_capture;

    assign cpu_claim = (state_q == C_IDLE) && cpu_req;

`ifdef IMG_ARB_STARVE_GUARD_EN
    localparam int              CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = STARVE_LIMIT[CNT_W-1:0];

    logic [CNT_W-1:0] starve_cnt;

    // Count consecutive refused CPU cycles in C_IDLE; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_grant) begin
            starve_cnt <= '0;
        end else if ((state_q == C_IDLE) && (starve_cnt != LIMIT_CNT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign starve_force = (starve_cnt == LIMIT_CNT);
`else
    // Strict display priority: the CPU-override term is constant zero
    // (the comparison only references the limit so it stays in the build).
    assign starve_force = (STARVE_LIMIT < 0);
`endif

    // Grant decision: display wins unless the starving CPU is being forced
    // through; nothing is granted while reset is asserted.
    always_comb begin
        vga_grant = 1'b0;
        cpu_grant = 1'b0;
        if (!reset) begin
            if (vga_req && !(cpu_claim && starve_force)) begin
                vga_grant = 1'b1;
            end else if (cpu_claim) begin
                cpu_grant = 1'b1;
            end
        end
    end

    // RAM port mux: owner drives address/data, idle cycles drive zeros.
    always_comb begin
        ram_adr   = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (vga_grant) begin
            ram_adr = vga_adr;
        end else if (cpu_grant) begin
            ram_adr   = cpu_adr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end
    end

    assign vga_gnt = vga_grant;

    // CPU stall: a granted write finishes in place, reads need two extra
    // cycles, a refused request waits.
    always_comb begin
        cpu_stall = 1'b0;
        case (state_q)
            C_IDLE:    cpu_stall = cpu_req && !(cpu_grant && cpu_we);
            C_RD_WAIT: cpu_stall = 1'b1;
            C_RD_DONE: cpu_stall = 1'b0;
            default:   cpu_stall = 1'b0;
        endcase
        if (reset) begin
            cpu_stall = 1'b0;
        end
    end

    // CPU sequencer next-state logic.
    always_comb begin
        state_d = C_IDLE;
        case (state_q)
            C_IDLE:    state_d = (cpu_grant && !cpu_we) ? C_RD_WAIT : C_IDLE;
            C_RD_WAIT: state_d = C_RD_DONE;
            C_RD_DONE: state_d = C_IDLE;
            default:   state_d = C_IDLE;
        endcase
    end

    // CPU sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tag pipeline: remember whether this cycle's RAM read belongs to the
    // CPU or the display so next cycle's ram_q reaches the right consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_tag_q <= 1'b0;
        end else begin
            rd_vld_q <= vga_grant || (cpu_grant && !cpu_we);
            rd_tag_q <= cpu_grant;
        end
    end

    assign cpu_capture = rd_vld_q && rd_tag_q;

    // CPU read data register: loads only on a CPU read return, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= '0;
        end else if (cpu_capture) begin
            cpu_rdata <= ram_q;
        end
    end

    // Display return path is unregistered: ram_q is already the registered
    // RAM output, so the valid strobe just lags the grant by one cycle.
    assign vga_rvalid = rd_vld_q && !rd_tag_q && !reset;
    assign vga_rdata  = ram_q;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a synchronous RAM model and a
// scoreboard of expected display read data.
module tb_img_mem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_adr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    int vectors    = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] vga_exp_q[$];
    logic [7:0]        mem [0:1023];
    logic              preload;

    img_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_adr(vga_adr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered output, read-before-write, preload adr=data.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i[7:0];
        end else if (ram_we) begin
            mem[ram_adr[9:0]] <= ram_wdata;
        end
        ram_q <= mem[ram_adr[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain: every display read return must match the queue head.
    always @(negedge clk) begin
        if (vga_rvalid === 1'b1) begin
            if (vga_exp_q.size() == 0) check("vga_rvalid_unexpected", {31'd0, vga_rvalid}, 32'd0);
            else                       check("vga_rdata", {24'd0, vga_rdata}, {24'd0, vga_exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        vga_req = 1'b0; vga_adr = '0;
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        idle_inputs();
        tick();
        preload = 1'b0;

        // Reset with both requesters active: nothing may be granted.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h10; cpu_wdata = 8'h11;
        vga_req = 1'b1; vga_adr = 19'h5;
        @(negedge clk);
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_vga_gnt",   {31'd0, vga_gnt},   32'd0);
        check("rst_vga_rvalid",{31'd0, vga_rvalid},32'd0);
        check("rst_ram_we",    {31'd0, ram_we},    32'd0);
        check("rst_ram_adr",   {13'd0, ram_adr},   32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("idle_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("idle_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("idle_ram_adr",   {13'd0, ram_adr},   32'd0);
        tick();

        // Single-cycle CPU write of 0xA5 to 0x10.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h10; cpu_wdata = 8'hA5;
        @(negedge clk);
        check("wr_ram_we",    {31'd0, ram_we},    32'd1);
        check("wr_ram_adr",   {13'd0, ram_adr},   32'h10);
        check("wr_ram_wdata", {24'd0, ram_wdata}, 32'hA5);
        check("wr_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();

        // CPU read of 0x10: stall 1,1,0 and data in the third cycle.
        cpu_we = 1'b0; cpu_wdata = '0;
        @(negedge clk);
        check("rd1_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check("rd1_ram_adr",   {13'd0, ram_adr},   32'h10);
        check("rd1_ram_we",    {31'd0, ram_we},    32'd0);
        tick();
        @(negedge clk);
        check("rd2_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check("rd2_ram_adr",   {13'd0, ram_adr},   32'd0);
        tick();
        @(negedge clk);
        check("rd3_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rd3_cpu_rdata", {24'd0, cpu_rdata}, 32'hA5);
        tick();
        idle_inputs();

        // Collision: display read of 0x20 beats CPU write 0x3C -> 0x30.
        vga_req = 1'b1; vga_adr = 19'h20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h30; cpu_wdata = 8'h3C;
        vga_exp_q.push_back(8'h20);
        @(negedge clk);
        check("col_vga_gnt",   {31'd0, vga_gnt},   32'd1);
        check("col_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check("col_ram_adr",   {13'd0, ram_adr},   32'h20);
        check("col_ram_we",    {31'd0, ram_we},    32'd0);
        tick();
        vga_req = 1'b0; vga_adr = '0;
        @(negedge clk);
        check("col2_vga_gnt",   {31'd0, vga_gnt},   32'd0);
        check("col2_ram_we",    {31'd0, ram_we},    32'd1);
        check("col2_ram_adr",   {13'd0, ram_adr},   32'h30);
        check("col2_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        idle_inputs();

        // CPU read of 0x30 launched alone, then an 8-beat display stream
        // starts while the CPU sits in its wait/done states.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 19'h30;
        @(negedge clk);
        check("srd_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) cpu_req = 1'b0;
            vga_req = 1'b1; vga_adr = ADDR_W'(k);
            vga_exp_q.push_back(8'(k));
            @(negedge clk);
            check($sformatf("str%0d_vga_gnt", k), {31'd0, vga_gnt}, 32'd1);
            check($sformatf("str%0d_ram_adr", k), {13'd0, ram_adr}, 32'(k));
            if (k == 0) check("str0_cpu_stall", {31'd0, cpu_stall}, 32'd1);
            if (k == 1) begin
                check("str1_cpu_stall", {31'd0, cpu_stall}, 32'd0);
                check("str1_cpu_rdata", {24'd0, cpu_rdata}, 32'h3C);
            end
            if (k >= 1) check($sformatf("str%0d_vga_rvalid", k), {31'd0, vga_rvalid}, 32'd1);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("str_tail_vga_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check("str_tail_cpu_rdata",  {24'd0, cpu_rdata},  32'h3C);
        tick();
        @(negedge clk);
        check("str_end_vga_rvalid", {31'd0, vga_rvalid}, 32'd0);
        tick();

        // Starvation: both requesters held.
        vga_req = 1'b1; vga_adr = 19'h40;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h50; cpu_wdata = 8'h77;
`ifdef IMG_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 5; k++) begin
            if (k < 4) vga_exp_q.push_back(8'h40);
            @(negedge clk);
            check($sformatf("stv%0d_vga_gnt", k),   {31'd0, vga_gnt},   (k == 4) ? 32'd0 : 32'd1);
            check($sformatf("stv%0d_ram_we", k),    {31'd0, ram_we},    (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("stv%0d_cpu_stall", k), {31'd0, cpu_stall}, (k == 4) ? 32'd0 : 32'd1);
            tick();
        end
`else
        for (int k = 0; k < 8; k++) begin
            vga_exp_q.push_back(8'h40);
            @(negedge clk);
            check($sformatf("stv%0d_vga_gnt", k),   {31'd0, vga_gnt},   32'd1);
            check($sformatf("stv%0d_ram_we", k),    {31'd0, ram_we},    32'd0);
            check($sformatf("stv%0d_cpu_stall", k), {31'd0, cpu_stall}, 32'd1);
            tick();
        end
`endif
        idle_inputs();
        tick();
        tick();

        // Reset while the CPU waits for read data: read is abandoned.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 19'h10;
        @(negedge clk);
        check("rrd1_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        reset = 1'b1; vga_req = 1'b1; vga_adr = 19'h3;
        @(negedge clk);
        check("rrd2_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rrd2_vga_gnt",   {31'd0, vga_gnt},   32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rrd3_cpu_stall",  {31'd0, cpu_stall},  32'd0);
        check("rrd3_vga_rvalid", {31'd0, vga_rvalid}, 32'd0);
        check("rrd3_cpu_rdata",  {24'd0, cpu_rdata},  32'd0);
        tick();
        // Back in C_IDLE: a write is accepted immediately.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h60; cpu_wdata = 8'h5A;
        @(negedge clk);
        check("rrd4_ram_we",    {31'd0, ram_we},    32'd1);
        check("rrd4_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        idle_inputs();
        tick();
        tick();

        check("vga_scoreboard_empty", 32'(vga_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
